// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// Core-side OVI issue controller: scoreboard ID allocation, issue credits,
// in-order dispatch pairing and completion retirement in front of tt_vpu_ovi.

package tt_vpu_ovi_issue_ctrl_pkg;
    typedef enum logic [1:0] {
        SB_FREE       = 2'd0,
        SB_ISSUED     = 2'd1,
        SB_DISPATCHED = 2'd2
    } sb_state_e;
endpackage

module tt_vpu_ovi_issue_ctrl_slot
    import tt_vpu_ovi_issue_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      alloc,
    input  logic      dispatch_senior,
    input  logic      dispatch_kill,
    input  logic      complete,
    output sb_state_e state
);
    sb_state_e state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SB_FREE;
        else       state <= state_next;
    end

    // Dispatch is applied last so a bypassed dispatch overrides its own allocation.
    always_comb begin
        state_next = state;
        if (complete && state == SB_DISPATCHED) state_next = SB_FREE;
        if (alloc)                              state_next = SB_ISSUED;
        if (dispatch_senior)                    state_next = SB_DISPATCHED;
        else if (dispatch_kill)                 state_next = SB_FREE;
    end
endmodule

module tt_vpu_ovi_issue_ctrl
    import tt_vpu_ovi_issue_ctrl_pkg::*;
#(
    parameter int CREDITS = 16,
    parameter int NUM_SB  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_issue_valid,
    output logic        core_issue_ready,
    input  logic [31:0] core_issue_inst,
    input  logic [63:0] core_issue_scalar_opnd,
    input  logic [39:0] core_issue_vcsr,
    input  logic        core_issue_vcsr_lmulb2,
    output logic [4:0]  core_issue_sb_id,
    input  logic        core_dispatch_valid,
    input  logic        core_dispatch_kill,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [4:0]  issue_sb_id,
    output logic [63:0] issue_scalar_opnd,
    output logic [39:0] issue_vcsr,
    output logic        issue_vcsr_lmulb2,
    input  logic        issue_credit,
    output logic [4:0]  dispatch_sb_id,
    output logic        dispatch_next_senior,
    output logic        dispatch_kill,
    input  logic        completed_valid,
    input  logic [4:0]  completed_sb_id,
    input  logic [4:0]  completed_fflags,
    input  logic [63:0] completed_dest_reg,
    input  logic        completed_vxsat,
    input  logic [13:0] completed_vstart,
    input  logic        completed_illegal,
    output logic        cpl_valid,
    output logic [4:0]  cpl_sb_id,
    output logic [4:0]  cpl_fflags,
    output logic [63:0] cpl_dest_reg,
    output logic        cpl_vxsat,
    output logic [13:0] cpl_vstart,
    output logic        cpl_illegal,
    output logic [5:0]  credit_cnt,
    output logic [5:0]  outstanding_cnt,
    output logic        err_protocol
);
    localparam logic [5:0] CREDIT_MAX = 6'(CREDITS);

    sb_state_e         sb_state [NUM_SB];
    logic [NUM_SB-1:0] free_vec;
    logic [4:0]        alloc_id;
    logic              accept;

    logic [4:0] fifo_mem [NUM_SB];
    logic [4:0] wr_ptr, rd_ptr;
    logic [5:0] fifo_cnt;
    logic       fifo_empty, fifo_push;

    logic       disp_pop, disp_bypass, disp_go, disp_err;
    logic [4:0] disp_id;
    logic       credit_err, cpl_err;
    logic [5:0] credit_next;

    // Lowest free ID wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_SB - 1; i >= 0; i--)
            if (free_vec[i]) alloc_id = 5'(i);
    end

    assign core_issue_ready = (credit_cnt != 6'd0) && (|free_vec);
    assign core_issue_sb_id = alloc_id;
    assign accept           = core_issue_valid && core_issue_ready;

    assign fifo_empty  = (fifo_cnt == 6'd0);
    assign disp_pop    = core_dispatch_valid && !fifo_empty;
    assign disp_bypass = core_dispatch_valid && fifo_empty && accept;
    assign disp_err    = core_dispatch_valid && fifo_empty && !accept;
    assign disp_go     = disp_pop || disp_bypass;
    assign disp_id     = disp_pop ? fifo_mem[rd_ptr] : alloc_id;
    assign fifo_push   = accept && !disp_bypass;

    generate
        for (genvar i = 0; i < NUM_SB; i++) begin : g_slot
            tt_vpu_ovi_issue_ctrl_slot u_slot (
                .clk             (clk),
                .reset           (reset),
                .alloc           (accept && alloc_id == 5'(i)),
                .dispatch_senior (disp_go && !core_dispatch_kill && disp_id == 5'(i)),
                .dispatch_kill   (disp_go && core_dispatch_kill && disp_id == 5'(i)),
                .complete        (completed_valid && completed_sb_id == 5'(i)),
                .state           (sb_state[i])
            );
            assign free_vec[i] = (sb_state[i] == SB_FREE);
        end
    endgenerate

    always_comb begin
        outstanding_cnt = '0;
        for (int i = 0; i < NUM_SB; i++)
            outstanding_cnt = outstanding_cnt + {5'd0, ~free_vec[i]};
    end

    assign cpl_err = completed_valid && (sb_state[completed_sb_id] != SB_DISPATCHED);

    // A returned credit at the ceiling is a VPU bug; the count saturates.
    assign credit_err = issue_credit && !accept && (credit_cnt == CREDIT_MAX);
    always_comb begin
        credit_next = credit_cnt;
        unique case ({accept, issue_credit})
            2'b10:   credit_next = credit_cnt - 6'd1;
            2'b01:   credit_next = credit_err ? credit_cnt : credit_cnt + 6'd1;
            default: credit_next = credit_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= alloc_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 5'd1;
            if (disp_pop)  rd_ptr <= rd_ptr + 5'd1;
            unique case ({fifo_push, disp_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 6'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 6'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_cnt   <= CREDIT_MAX;
            err_protocol <= 1'b0;
        end else begin
            credit_cnt   <= credit_next;
            err_protocol <= err_protocol | credit_err | disp_err | cpl_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid       <= 1'b0;
            issue_inst        <= '0;
            issue_sb_id       <= '0;
            issue_scalar_opnd <= '0;
            issue_vcsr        <= '0;
            issue_vcsr_lmulb2 <= 1'b0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                issue_inst        <= core_issue_inst;
                issue_sb_id       <= alloc_id;
                issue_scalar_opnd <= core_issue_scalar_opnd;
                issue_vcsr        <= core_issue_vcsr;
                issue_vcsr_lmulb2 <= core_issue_vcsr_lmulb2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dispatch_sb_id       <= '0;
            dispatch_next_senior <= 1'b0;
            dispatch_kill        <= 1'b0;
        end else begin
            dispatch_next_senior <= disp_go && !core_dispatch_kill;
            dispatch_kill        <= disp_go && core_dispatch_kill;
            if (disp_go) dispatch_sb_id <= disp_id;
        end
    end

    // Completions are forwarded even when flagged as protocol errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpl_valid    <= 1'b0;
            cpl_sb_id    <= '0;
            cpl_fflags   <= '0;
            cpl_dest_reg <= '0;
            cpl_vxsat    <= 1'b0;
            cpl_vstart   <= '0;
            cpl_illegal  <= 1'b0;
        end else begin
            cpl_valid <= completed_valid;
            if (completed_valid) begin
                cpl_sb_id    <= completed_sb_id;
                cpl_fflags   <= completed_fflags;
                cpl_dest_reg <= completed_dest_reg;
                cpl_vxsat    <= completed_vxsat;
                cpl_vstart   <= completed_vstart;
                cpl_illegal  <= completed_illegal;
            end
        end
    end
endmodule

// File: tb/tb_tt_vpu_ovi_issue_ctrl.sv
// Table-driven bench for tt_vpu_ovi_issue_ctrl with scoreboard queues for
// the registered issue, dispatch and completion buses.

module tb_tt_vpu_ovi_issue_ctrl;
    localparam int CREDITS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_issue_valid = 1'b0, core_issue_ready;
    logic [31:0] core_issue_inst = '0;
    logic [63:0] core_issue_scalar_opnd = '0;
    logic [39:0] core_issue_vcsr = '0;
    logic        core_issue_vcsr_lmulb2 = 1'b0;
    logic [4:0]  core_issue_sb_id;
    logic        core_dispatch_valid = 1'b0, core_dispatch_kill = 1'b0;
    logic        issue_valid, issue_vcsr_lmulb2;
    logic [31:0] issue_inst;
    logic [4:0]  issue_sb_id;
    logic [63:0] issue_scalar_opnd;
    logic [39:0] issue_vcsr;
    logic        issue_credit = 1'b0;
    logic [4:0]  dispatch_sb_id;
    logic        dispatch_next_senior, dispatch_kill;
    logic        completed_valid = 1'b0, completed_vxsat = 1'b0, completed_illegal = 1'b0;
    logic [4:0]  completed_sb_id = '0, completed_fflags = '0;
    logic [63:0] completed_dest_reg = '0;
    logic [13:0] completed_vstart = '0;
    logic        cpl_valid, cpl_vxsat, cpl_illegal;
    logic [4:0]  cpl_sb_id, cpl_fflags;
    logic [63:0] cpl_dest_reg;
    logic [13:0] cpl_vstart;
    logic [5:0]  credit_cnt, outstanding_cnt;
    logic        err_protocol;

    always #5 clk = ~clk;

    tt_vpu_ovi_issue_ctrl #(.CREDITS(CREDITS), .NUM_SB(32)) dut (
        .clk(clk), .reset(reset),
        .core_issue_valid(core_issue_valid), .core_issue_ready(core_issue_ready),
        .core_issue_inst(core_issue_inst), .core_issue_scalar_opnd(core_issue_scalar_opnd),
        .core_issue_vcsr(core_issue_vcsr), .core_issue_vcsr_lmulb2(core_issue_vcsr_lmulb2),
        .core_issue_sb_id(core_issue_sb_id),
        .core_dispatch_valid(core_dispatch_valid), .core_dispatch_kill(core_dispatch_kill),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_sb_id(issue_sb_id),
        .issue_scalar_opnd(issue_scalar_opnd), .issue_vcsr(issue_vcsr),
        .issue_vcsr_lmulb2(issue_vcsr_lmulb2), .issue_credit(issue_credit),
        .dispatch_sb_id(dispatch_sb_id), .dispatch_next_senior(dispatch_next_senior),
        .dispatch_kill(dispatch_kill),
        .completed_valid(completed_valid), .completed_sb_id(completed_sb_id),
        .completed_fflags(completed_fflags), .completed_dest_reg(completed_dest_reg),
        .completed_vxsat(completed_vxsat), .completed_vstart(completed_vstart),
        .completed_illegal(completed_illegal),
        .cpl_valid(cpl_valid), .cpl_sb_id(cpl_sb_id), .cpl_fflags(cpl_fflags),
        .cpl_dest_reg(cpl_dest_reg), .cpl_vxsat(cpl_vxsat), .cpl_vstart(cpl_vstart),
        .cpl_illegal(cpl_illegal),
        .credit_cnt(credit_cnt), .outstanding_cnt(outstanding_cnt), .err_protocol(err_protocol)
    );

    int errors = 0;
    int checks = 0;

    logic [141:0] q_iss [$];
    logic [6:0]   q_dsp [$];
    logic [89:0]  q_cpl [$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: pop an expectation for every registered output pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (issue_valid) begin
                if (q_iss.size() == 0) chk("issue_unexpected", 160'(issue_valid), 160'(0));
                else chk("issue_bus", 160'({issue_sb_id, issue_inst, issue_scalar_opnd,
                                            issue_vcsr, issue_vcsr_lmulb2}), 160'(q_iss.pop_front()));
            end
            if (dispatch_next_senior || dispatch_kill) begin
                if (q_dsp.size() == 0)
                    chk("dispatch_unexpected", 160'({dispatch_next_senior, dispatch_kill}), 160'(0));
                else chk("dispatch_bus", 160'({dispatch_sb_id, dispatch_next_senior, dispatch_kill}),
                         160'(q_dsp.pop_front()));
            end
            if (cpl_valid) begin
                if (q_cpl.size() == 0) chk("cpl_unexpected", 160'(cpl_valid), 160'(0));
                else chk("cpl_bus", 160'({cpl_sb_id, cpl_fflags, cpl_dest_reg, cpl_vxsat,
                                          cpl_vstart, cpl_illegal}), 160'(q_cpl.pop_front()));
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic iv, input logic dv, input logic dk, input logic cv,
                         input logic [4:0] cid, input logic cr, input logic [4:0] exp_iss,
                         input logic exp_disp, input logic [4:0] exp_did);
        core_issue_valid       = iv;
        core_issue_inst        = $urandom;
        core_issue_scalar_opnd = {$urandom, $urandom};
        core_issue_vcsr        = {8'($urandom), 32'($urandom)};
        core_issue_vcsr_lmulb2 = 1'($urandom_range(0, 1));
        if (iv) q_iss.push_back({exp_iss, core_issue_inst, core_issue_scalar_opnd,
                                 core_issue_vcsr, core_issue_vcsr_lmulb2});
        core_dispatch_valid = dv;
        core_dispatch_kill  = dk;
        if (exp_disp) q_dsp.push_back({exp_did, ~dk, dk});
        completed_valid    = cv;
        completed_sb_id    = cid;
        completed_fflags   = 5'($urandom);
        completed_dest_reg = {$urandom, $urandom};
        completed_vxsat    = 1'($urandom_range(0, 1));
        completed_vstart   = 14'($urandom);
        completed_illegal  = 1'($urandom_range(0, 1));
        if (cv) q_cpl.push_back({cid, completed_fflags, completed_dest_reg, completed_vxsat,
                                 completed_vstart, completed_illegal});
        issue_credit = cr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    endtask

    task automatic do_reset();
        chk("q_iss_drained", 160'(q_iss.size()), 160'(0));
        chk("q_dsp_drained", 160'(q_dsp.size()), 160'(0));
        chk("q_cpl_drained", 160'(q_cpl.size()), 160'(0));
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_credit", 160'(credit_cnt), 160'(CREDITS));
        chk("rst_outputs", 160'({issue_valid, dispatch_next_senior, dispatch_kill, cpl_valid,
                                 err_protocol, outstanding_cnt}), 160'(0));
        nxt();
        reset = 1'b0;
    endtask

    typedef struct {
        logic iv, dv, dk, cv;
        logic [4:0] cid;
        logic cr;
        logic e_ready;
        logic [4:0] e_sb;
        logic [5:0] e_ccnt, e_out;
        logic e_err, e_disp;
        logic [4:0] e_did;
    } vec_t;

    vec_t vt [20];

    initial begin
        //         iv dv dk cv cid  cr  rdy sb    ccnt  out  err disp did
        vt[0]  = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd16, 6'd0, 0, 0, 5'd0};
        vt[1]  = '{1, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd16, 6'd0, 0, 0, 5'd0};
        vt[2]  = '{1, 0, 0, 0, 5'd0, 0, 1, 5'd1, 6'd15, 6'd1, 0, 0, 5'd0};
        vt[3]  = '{1, 0, 0, 0, 5'd0, 0, 1, 5'd2, 6'd14, 6'd2, 0, 0, 5'd0};
        vt[4]  = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd3, 6'd13, 6'd3, 0, 0, 5'd0};
        vt[5]  = '{0, 1, 0, 0, 5'd0, 0, 1, 5'd3, 6'd13, 6'd3, 0, 1, 5'd0};
        vt[6]  = '{0, 1, 1, 0, 5'd0, 0, 1, 5'd3, 6'd13, 6'd3, 0, 1, 5'd1};
        vt[7]  = '{0, 1, 0, 0, 5'd0, 0, 1, 5'd1, 6'd13, 6'd2, 0, 1, 5'd2};
        vt[8]  = '{0, 0, 0, 1, 5'd0, 0, 1, 5'd1, 6'd13, 6'd2, 0, 0, 5'd0};
        vt[9]  = '{0, 0, 0, 1, 5'd2, 0, 1, 5'd0, 6'd13, 6'd1, 0, 0, 5'd0};
        vt[10] = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd13, 6'd0, 0, 0, 5'd0};
        vt[11] = '{1, 1, 0, 0, 5'd0, 0, 1, 5'd0, 6'd13, 6'd0, 0, 1, 5'd0};
        vt[12] = '{0, 0, 0, 1, 5'd0, 1, 1, 5'd1, 6'd12, 6'd1, 0, 0, 5'd0};
        vt[13] = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd13, 6'd0, 0, 0, 5'd0};
        vt[14] = '{1, 0, 0, 0, 5'd0, 1, 1, 5'd0, 6'd13, 6'd0, 0, 0, 5'd0};
        vt[15] = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd1, 6'd13, 6'd1, 0, 0, 5'd0};
        vt[16] = '{0, 1, 1, 0, 5'd0, 0, 1, 5'd1, 6'd13, 6'd1, 0, 1, 5'd0};
        vt[17] = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd13, 6'd0, 0, 0, 5'd0};
        vt[18] = '{0, 0, 0, 1, 5'd5, 0, 1, 5'd0, 6'd13, 6'd0, 0, 0, 5'd0};
        vt[19] = '{0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 6'd13, 6'd0, 1, 0, 5'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_credit", 160'(credit_cnt), 160'(CREDITS));
        chk("rst_outputs", 160'({issue_valid, dispatch_next_senior, dispatch_kill, cpl_valid,
                                 err_protocol, outstanding_cnt}), 160'(0));
        nxt();
        reset = 1'b0;

        // Main table: issue, dispatch, kill, bypass, completion, credit, error.
        for (int r = 0; r < 20; r++) begin
            drive(vt[r].iv, vt[r].dv, vt[r].dk, vt[r].cv, vt[r].cid, vt[r].cr,
                  vt[r].e_sb, vt[r].e_disp, vt[r].e_did);
            @(negedge clk);
            chk($sformatf("row%0d_ready", r), 160'(core_issue_ready), 160'(vt[r].e_ready));
            chk($sformatf("row%0d_sb_id", r), 160'(core_issue_sb_id), 160'(vt[r].e_sb));
            chk($sformatf("row%0d_credit", r), 160'(credit_cnt), 160'(vt[r].e_ccnt));
            chk($sformatf("row%0d_outstanding", r), 160'(outstanding_cnt), 160'(vt[r].e_out));
            chk($sformatf("row%0d_err", r), 160'(err_protocol), 160'(vt[r].e_err));
            nxt();
        end
        idle();
        nxt();

        // Dispatch with empty FIFO and no accept: error, no dispatch pulse.
        do_reset();
        drive(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("empty_disp_err_before", 160'(err_protocol), 160'(0));
        nxt();
        idle();
        @(negedge clk);
        chk("empty_disp_err", 160'(err_protocol), 160'(1));
        chk("empty_disp_no_out", 160'({dispatch_next_senior, dispatch_kill}), 160'(0));
        nxt();

        // Credit returned at the ceiling: error, count saturates.
        do_reset();
        drive(0, 0, 0, 0, 5'd0, 1, 5'd0, 0, 5'd0);
        nxt();
        idle();
        @(negedge clk);
        chk("credit_ovf_err", 160'(err_protocol), 160'(1));
        chk("credit_ovf_cnt", 160'(credit_cnt), 160'(CREDITS));
        nxt();

        // Credit exhaustion, then fill all 32 IDs with credit returns.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 5'd0, 0, 5'(i), 0, 5'd0);
            @(negedge clk);
            chk($sformatf("exh_sb%0d", i), 160'({core_issue_ready, core_issue_sb_id}),
                160'({1'b1, 5'(i)}));
            nxt();
        end
        idle();
        @(negedge clk);
        chk("exh_ready", 160'(core_issue_ready), 160'(0));
        chk("exh_credit", 160'(credit_cnt), 160'(0));
        chk("exh_outstanding", 160'(outstanding_cnt), 160'(16));
        nxt();
        drive(0, 0, 0, 0, 5'd0, 1, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("exh_ready_same_cycle", 160'(core_issue_ready), 160'(0));
        nxt();
        idle();
        @(negedge clk);
        chk("exh_ready_after_credit", 160'({core_issue_ready, credit_cnt}), 160'({1'b1, 6'd1}));
        nxt();
        for (int i = 16; i < 32; i++) begin
            drive(1, 0, 0, 0, 5'd0, 1, 5'(i), 0, 5'd0);
            @(negedge clk);
            chk($sformatf("fill_sb%0d", i), 160'({core_issue_ready, core_issue_sb_id}),
                160'({1'b1, 5'(i)}));
            chk($sformatf("fill_credit%0d", i), 160'(credit_cnt), 160'(1));
            nxt();
        end
        idle();
        @(negedge clk);
        chk("full_ready", 160'(core_issue_ready), 160'(0));
        chk("full_outstanding", 160'(outstanding_cnt), 160'(32));
        chk("full_credit", 160'(credit_cnt), 160'(1));
        chk("full_err", 160'(err_protocol), 160'(0));
        nxt();

        // Reset with every ID outstanding.
        do_reset();
        @(negedge clk);
        chk("post_rst_state", 160'({core_issue_ready, core_issue_sb_id, credit_cnt,
                                    outstanding_cnt, err_protocol}),
            160'({1'b1, 5'd0, 6'(CREDITS), 6'd0, 1'b0}));
        nxt();

        chk("final_q_iss", 160'(q_iss.size()), 160'(0));
        chk("final_q_dsp", 160'(q_dsp.size()), 160'(0));
        chk("final_q_cpl", 160'(q_cpl.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
